alu_pipe: RTL

//  Parametrised, pipelined arithmetic unit; successor to the single-cycle combinational adder.

---
 rtl/alu_pipe_pkg.sv | 18 +
 rtl/alu_pipe_exec.sv | 54 +++++
 rtl/alu_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and width helpers for the pipelined ALU.
package alu_pipe_pkg;

  localparam int C_OP_WIDTH = 3;

  localparam logic [C_OP_WIDTH-1:0] OP_ADD = 3'b000;
  localparam logic [C_OP_WIDTH-1:0] OP_SUB = 3'b001;
  localparam logic [C_OP_WIDTH-1:0] OP_MUL = 3'b010;
  localparam logic [C_OP_WIDTH-1:0] OP_MAC = 3'b011;
  localparam logic [C_OP_WIDTH-1:0] OP_CLR = 3'b100;
  localparam logic [C_OP_WIDTH-1:0] OP_MIN = 3'b101;

  // Full product width plus guard bits so the accumulator can absorb several MACs.
  function automatic int res_width(input int dw, input int guard);
    return 2 * dw + guard;
  endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational stage-2 datapath: turns a registered operand beat plus the
// current accumulator into a result, the next accumulator value and a wrap flag.
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int DW = 8,
  parameter int RW = 20
) (
  input  logic [C_OP_WIDTH-1:0] op,
  input  logic [DW-1:0]         a,
  input  logic [DW-1:0]         b,
  input  logic [RW-1:0]         acc,
  output logic [RW-1:0]         result,
  output logic [RW-1:0]         acc_next,
  output logic                  acc_we,
  output logic                  ovf
);

  localparam int PW = 2 * DW;

  logic [PW-1:0] prod;
  logic [DW:0]   diff;
  logic [RW:0]   mac_sum;

  assign prod    = PW'(a) * PW'(b);
  assign diff    = {1'b0, a} - {1'b0, b};
  // The extra top bit of the sum is the carry out of the accumulator MSB.
  assign mac_sum = {1'b0, acc} + (RW + 1)'(prod);

  always_comb begin
    result   = '0;
    acc_next = acc;
    acc_we   = 1'b0;
    ovf      = 1'b0;
    case (op)
      OP_ADD: result = RW'(a) + RW'(b);
      OP_SUB: result = {{(RW - DW - 1){diff[DW]}}, diff};
      OP_MUL: result = RW'(prod);
      OP_MIN: result = (a < b) ? RW'(a) : RW'(b);
      OP_MAC: begin
        result   = mac_sum[RW-1:0];
        acc_next = mac_sum[RW-1:0];
        acc_we   = 1'b1;
        ovf      = mac_sum[RW];
      end
      OP_CLR: begin
        acc_next = '0;
        acc_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with accumulator and valid/ready handshakes on both
// the operand and result sides; full back-pressure without beat loss.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int  C_DATA_WIDTH = 8,
  parameter int  C_ACC_GUARD  = 4,
  localparam int C_RES_WIDTH  = res_width(C_DATA_WIDTH, C_ACC_GUARD)
) (
  input  logic                    I_sys_clk,
  input  logic                    I_rst,
  input  logic                    I_valid,
  output logic                    O_ready,
  input  logic [C_OP_WIDTH-1:0]   I_op,
  input  logic [C_DATA_WIDTH-1:0] I_a,
  input  logic [C_DATA_WIDTH-1:0] I_b,
  output logic                    O_valid,
  input  logic                    I_ready,
  output logic [C_RES_WIDTH-1:0]  O_result,
  output logic                    O_ovf
);

  logic                    s1_valid;
  logic [C_OP_WIDTH-1:0]   s1_op;
  logic [C_DATA_WIDTH-1:0] s1_a;
  logic [C_DATA_WIDTH-1:0] s1_b;
  logic [C_RES_WIDTH-1:0]  acc;

  logic                    s2_load;
  logic                    accept;
  logic [C_RES_WIDTH-1:0]  exec_result;
  logic [C_RES_WIDTH-1:0]  exec_acc_next;
  logic                    exec_acc_we;
  logic                    exec_ovf;

  // Handshake: a beat moves on a side only in a cycle where that side's valid
  // and ready are both 1 at the clock edge; a valid producer holds its beat
  // unchanged until then. S2 reloads when it is empty or retiring this cycle,
  // so I_ready reaches O_ready combinationally and a full pipe still streams.
  assign s2_load = s1_valid && (!O_valid || I_ready);
  assign O_ready = !I_rst && (!s1_valid || s2_load);
  assign accept  = I_valid && O_ready;

  alu_pipe_exec #(
    .DW (C_DATA_WIDTH),
    .RW (C_RES_WIDTH)
  ) u_exec (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .acc      (acc),
    .result   (exec_result),
    .acc_next (exec_acc_next),
    .acc_we   (exec_acc_we),
    .ovf      (exec_ovf)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      O_valid  <= 1'b0;
      O_result <= '0;
      O_ovf    <= 1'b0;
      acc      <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= I_op;
        s1_a     <= I_a;
        s1_b     <= I_b;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      // The accumulator advances only when its beat commits to S2, so
      // back-to-back MACs see each other's result without a bubble.
      if (s2_load) begin
        O_valid  <= 1'b1;
        O_result <= exec_result;
        O_ovf    <= exec_ovf;
        if (exec_acc_we) begin
          acc <= exec_acc_next;
        end
      end else if (O_valid && I_ready) begin
        O_valid <= 1'b0;
      end
    end
  end

endmodule
